// File: rtl/mem_stage_if.sv
// Pipeline-side signal bundle of the memory-access stage: the execute-facing
// handshake, the write-back-facing handshake, the data-SRAM response and the
// forwarding/interlock bus back to decode.
interface mem_stage_if;
  // execute -> memory
  logic        es_to_ms_valid;
  logic [74:0] es_to_ms_bus;
  logic        ms_allowin;
  // memory -> write-back
  logic        ms_to_ws_valid;
  logic [69:0] ms_to_ws_bus;
  logic        ws_allowin;
  // data-SRAM response
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  // forwarding / interlock back to decode
  logic [38:0] ms_fwd_bus;

  // The memory stage itself.
  modport slave (
    input  es_to_ms_valid, es_to_ms_bus, ws_allowin,
           data_sram_data_ok, data_sram_rdata,
    output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_fwd_bus
  );

  // Everything around the memory stage (execute, write-back, SRAM, decode).
  modport master (
    output es_to_ms_valid, es_to_ms_bus, ws_allowin,
           data_sram_data_ok, data_sram_rdata,
    input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_fwd_bus
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: holds one instruction from execute, waits for the
// data-SRAM response of a load/store, extracts and extends load data, parks a
// response that arrives while write-back is stalled, and drives the
// forwarding/interlock bus back to decode.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  mem_stage_if.slave  ms_if
);

  // Field layout of the instruction handed over by execute (MSB first).
  typedef struct packed {
    logic        mem_req;
    logic [2:0]  ld_op;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } es_bus_t;

  // Load size/sign encodings.
  localparam logic [2:0] LD_W  = 3'b000;
  localparam logic [2:0] LD_B  = 3'b001;
  localparam logic [2:0] LD_H  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b011;
  localparam logic [2:0] LD_HU = 3'b100;

  // State
  logic        ms_valid_q,  ms_valid_d;
  es_bus_t     bus_r_q,     bus_r_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_data_q,  buf_data_d;

  // Handshake / datapath nets
  logic        resp_done;
  logic        ms_ready_go;
  logic        allowin;
  logic        take_buf;
  logic [31:0] raw_data;
  logic [1:0]  offset;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;
  logic [31:0] final_result;

  // Handshake: a memory instruction may only leave once its response is
  // either on the bus this cycle or already parked in the buffer.
  always_comb begin
    resp_done   = buf_valid_q | ms_if.data_sram_data_ok;
    ms_ready_go = ~bus_r_q.mem_req | resp_done;
    allowin     = ~ms_valid_q | (ms_ready_go & ms_if.ws_allowin);
    // A response only gets parked when it belongs to the resident memory
    // instruction and write-back cannot take it right now; stray strobes
    // (no instruction, no request, or buffer already full) fall through.
    take_buf    = ms_valid_q & bus_r_q.mem_req & ~buf_valid_q &
                  ms_if.data_sram_data_ok & ~ms_if.ws_allowin;
  end

  // Load data extraction: pick the byte/half addressed by the low address
  // bits and extend it; unknown ld_op codes behave like a full word load.
  always_comb begin
    raw_data = buf_valid_q ? buf_data_q : ms_if.data_sram_rdata;
    offset   = bus_r_q.alu_result[1:0];

    case (offset)
      2'd0:    ld_byte = raw_data[7:0];
      2'd1:    ld_byte = raw_data[15:8];
      2'd2:    ld_byte = raw_data[23:16];
      default: ld_byte = raw_data[31:24];
    endcase

    // Half selection ignores offset[0]; misalignment is trapped upstream.
    ld_half = offset[1] ? raw_data[31:16] : raw_data[15:0];

    case (bus_r_q.ld_op)
      LD_B:    load_data = {{24{ld_byte[7]}}, ld_byte};
      LD_BU:   load_data = {24'd0, ld_byte};
      LD_H:    load_data = {{16{ld_half[15]}}, ld_half};
      LD_HU:   load_data = {16'd0, ld_half};
      LD_W:    load_data = raw_data;
      default: load_data = raw_data;
    endcase

    final_result = bus_r_q.res_from_mem ? load_data : bus_r_q.alu_result;
  end

  // Next-state: accept from execute when there is room, otherwise capture a
  // response that write-back cannot consume this cycle.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it
    // unassigned; an unassigned path in always_comb would infer a latch.
    ms_valid_d  = ms_valid_q;
    bus_r_d     = bus_r_q;
    buf_valid_d = buf_valid_q;
    buf_data_d  = buf_data_q;

    if (allowin) begin
      ms_valid_d = ms_if.es_to_ms_valid;
      if (ms_if.es_to_ms_valid) begin
        bus_r_d     = ms_if.es_to_ms_bus;
        buf_valid_d = 1'b0;
      end
    end else if (take_buf) begin
      // take_buf implies ms_valid & !ws_allowin, hence allowin=0: the two
      // branches can never both want to fire.
      buf_valid_d = 1'b1;
      buf_data_d  = ms_if.data_sram_rdata;
    end
  end

  // Stage registers; reset drops any resident instruction and its response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_valid_q  <= 1'b0;
      bus_r_q     <= '0;
      buf_valid_q <= 1'b0;
      buf_data_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values
      // regardless of statement order.
      ms_valid_q  <= ms_valid_d;
      bus_r_q     <= bus_r_d;
      buf_valid_q <= buf_valid_d;
      buf_data_q  <= buf_data_d;
    end
  end

  // Outputs: all derived from state plus the SRAM response and ws_allowin;
  // nothing from execute reaches an output combinationally.
  assign ms_if.ms_allowin     = allowin;
  assign ms_if.ms_to_ws_valid = ms_valid_q & ms_ready_go;
  assign ms_if.ms_to_ws_bus   = {bus_r_q.gr_we, bus_r_q.dest, final_result, bus_r_q.pc};
  assign ms_if.ms_fwd_bus     = {ms_valid_q & bus_r_q.gr_we,
                                 bus_r_q.dest,
                                 final_result,
                                 ms_valid_q & bus_r_q.res_from_mem & ~resp_done};

  // Write-back sees a stable offer until it accepts it.
  property p_offer_stable;
    @(posedge clk) disable iff (reset)
      (ms_if.ms_to_ws_valid && !ms_if.ws_allowin) |=>
        (ms_if.ms_to_ws_valid && $stable(ms_if.ms_to_ws_bus));
  endproperty
  a_offer_stable: assert property (p_offer_stable);

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a stimulus process issues instructions and
// pushes expected write-back results, an SRAM model returns responses after a
// chosen delay, and a monitor compares every offered result and the per-cycle
// handshake/interlock behaviour.
module tb_mem_stage;

  logic clk = 1'b0;
  logic reset;

  mem_stage_if ms_if ();

  mem_stage dut (
    .clk   (clk),
    .reset (reset),
    .ms_if (ms_if)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        mem_req;
    logic [2:0]  ld_op;
    logic        rfm;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic [31:0] pc;
  } instr_t;

  typedef struct {
    logic        mem_req;
    logic        rfm;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] final_v;
    logic [31:0] pc;
    bit          has_want;
    logic [31:0] want;
  } exp_t;

  typedef struct {
    int          dly;
    logic [31:0] rdata;
  } sram_t;

  exp_t  exp_q[$];
  sram_t sram_q[$];
  int    checks   = 0;
  int    failures = 0;
  bit    resp_arrived = 1'b0;
  bit    ws_force_en  = 1'b1;
  logic  ws_force_val = 1'b1;

  task automatic check(input string name, input logic [69:0] act, input logic [69:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Reference load semantics from plain shifts and range tests.
  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] rd,
                                           input logic [1:0] off);
    logic [31:0] b, h;
    b = (rd >> (8 * off)) & 32'h0000_00FF;
    h = (rd >> (16 * off[1])) & 32'h0000_FFFF;
    case (op)
      3'd1:    return (b >= 32'd128)   ? (b | 32'hFFFF_FF00) : b;
      3'd3:    return b;
      3'd2:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      3'd4:    return h;
      default: return rd;
    endcase
  endfunction

  function automatic instr_t mk(input logic mem_req, input logic [2:0] op, input logic rfm,
                                input logic we, input logic [4:0] dest,
                                input logic [31:0] alu, input logic [31:0] pc);
    instr_t i;
    i.mem_req = mem_req; i.ld_op = op; i.rfm = rfm; i.gr_we = we;
    i.dest = dest; i.alu = alu; i.pc = pc;
    return i;
  endfunction

  // Present one instruction (caller is just after a posedge) until accepted,
  // then record what write-back must receive and what the SRAM will return.
  task automatic issue(input instr_t in, input logic [31:0] rd, input int dly,
                       input bit has_want, input logic [31:0] want);
    exp_t  e;
    sram_t s;
    int    n;
    ms_if.es_to_ms_valid = 1'b1;
    ms_if.es_to_ms_bus   = in;
    n = 0;
    forever begin
      @(negedge clk);
      if (ms_if.ms_allowin === 1'b1) break;
      n++;
      if (n >= 60) break;
    end
    if (n >= 60) begin
      check("accept_timeout", {69'd0, ms_if.ms_allowin}, 70'd1);
    end else begin
      #1;
      e.mem_req  = in.mem_req;
      e.rfm      = in.rfm;
      e.gr_we    = in.gr_we;
      e.dest     = in.dest;
      e.final_v  = in.rfm ? ref_load(in.ld_op, rd, in.alu[1:0]) : in.alu;
      e.pc       = in.pc;
      e.has_want = has_want;
      e.want     = want;
      exp_q.push_back(e);
      if (in.mem_req) begin
        s.dly   = dly;
        s.rdata = rd;
        sram_q.push_back(s);
      end
    end
    @(posedge clk);
    #1;
    ms_if.es_to_ms_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", {69'd0, exp_q.size() == 0}, 70'd1);
  endtask

  // Data-SRAM model: one response per request, after the requested delay,
  // counted from the first cycle the instruction sits in the stage.
  initial begin : sram_model
    sram_t e;
    ms_if.data_sram_data_ok = 1'b0;
    ms_if.data_sram_rdata   = '0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        ms_if.data_sram_data_ok = 1'b0;
        continue;
      end
      if (sram_q.size() > 0 && sram_q[0].dly == 0) begin
        e = sram_q.pop_front();
        ms_if.data_sram_data_ok = 1'b1;
        ms_if.data_sram_rdata   = e.rdata;
        resp_arrived = 1'b1;
      end else begin
        if (sram_q.size() > 0) begin
          e = sram_q[0];
          e.dly--;
          sram_q[0] = e;
        end
        ms_if.data_sram_data_ok = 1'b0;
        ms_if.data_sram_rdata   = $urandom;
      end
    end
  end

  // Write-back readiness: forced during directed tests, random otherwise.
  initial begin : ws_driver
    ms_if.ws_allowin = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      ms_if.ws_allowin = ws_force_en ? ws_force_val : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: per-cycle handshake/interlock expectations and result compare.
  initial begin : monitor
    exp_t h;
    bit   vexp;
    forever begin
      @(negedge clk);
      if (reset) continue;
      if (exp_q.size() == 0) begin
        resp_arrived = 1'b0;
        check("idle_valid",   {69'd0, ms_if.ms_to_ws_valid}, 70'd0);
        check("idle_allowin", {69'd0, ms_if.ms_allowin},     70'd1);
      end else begin
        h    = exp_q[0];
        vexp = !h.mem_req || resp_arrived;
        check("valid",   {69'd0, ms_if.ms_to_ws_valid}, {69'd0, vexp});
        check("pending", {69'd0, ms_if.ms_fwd_bus[0]},  {69'd0, h.rfm && !resp_arrived});
        check("allowin", {69'd0, ms_if.ms_allowin},     {69'd0, vexp && ms_if.ws_allowin});
        if (vexp && ms_if.ws_allowin) begin
          check("ws_bus", ms_if.ms_to_ws_bus, {h.gr_we, h.dest, h.final_v, h.pc});
          check("fwd_bus", {31'd0, ms_if.ms_fwd_bus}, {31'd0, h.gr_we, h.dest, h.final_v, 1'b0});
          if (h.has_want)
            check("final_result", {38'd0, ms_if.ms_to_ws_bus[63:32]}, {38'd0, h.want});
          void'(exp_q.pop_front());
          resp_arrived = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin : stimulus
    instr_t in;
    int     gap, dly;
    logic   mr, rfm;

    reset = 1'b1;
    ms_if.es_to_ms_valid = 1'b0;
    ms_if.es_to_ms_bus   = '0;
    #3;
    check("rst_allowin", {69'd0, ms_if.ms_allowin},     70'd1);
    check("rst_valid",   {69'd0, ms_if.ms_to_ws_valid}, 70'd0);
    check("rst_ws_bus",  ms_if.ms_to_ws_bus,            70'd0);
    check("rst_fwd_bus", {31'd0, ms_if.ms_fwd_bus},     70'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;

    // Zero-stall word and sub-word loads, back to back.
    issue(mk(1, 3'b000, 1, 1, 5'd3, 32'h0000_1000, 32'h100), 32'h1234_5678, 0, 1, 32'h1234_5678);
    issue(mk(1, 3'b001, 1, 1, 5'd4, 32'h0000_1003, 32'h104), 32'h80FF_1234, 0, 1, 32'hFFFF_FF80);
    issue(mk(1, 3'b011, 1, 1, 5'd5, 32'h0000_1002, 32'h108), 32'h80FF_1234, 0, 1, 32'h0000_00FF);
    issue(mk(1, 3'b100, 1, 1, 5'd6, 32'h0000_1002, 32'h10C), 32'h80FF_1234, 0, 1, 32'h0000_80FF);
    issue(mk(1, 3'b010, 1, 1, 5'd8, 32'h0000_1000, 32'h110), 32'h80FF_1234, 0, 1, 32'h0000_1234);
    // Response three cycles late.
    issue(mk(1, 3'b000, 1, 1, 5'd9, 32'h0000_2000, 32'h114), 32'hDEAD_BEEF, 3, 1, 32'hDEAD_BEEF);
    drain();

    // Response arrives while write-back is stalled; held for two more cycles.
    ws_force_val = 1'b0;
    issue(mk(1, 3'b000, 1, 1, 5'd10, 32'h0000_3000, 32'h118), 32'hCAFE_F00D, 0, 1, 32'hCAFE_F00D);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1 ws_force_val = 1'b1;
    drain();

    // Non-memory instruction forwards immediately.
    issue(mk(0, 3'b000, 0, 1, 5'd7, 32'hA5A5_A5A5, 32'h11C), 32'h0, 0, 1, 32'hA5A5_A5A5);
    drain();

    // Randomized traffic with random write-back stalls and response delays.
    ws_force_en = 1'b0;
    for (int i = 0; i < 300; i++) begin
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      mr  = ($urandom_range(0, 2) != 0);
      rfm = mr && ($urandom_range(0, 3) != 0);
      in  = mk(mr, 3'($urandom_range(0, 7)), rfm, mr ? rfm : 1'($urandom_range(0, 1)),
               5'($urandom), $urandom, $urandom);
      dly = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      issue(in, $urandom, dly, 0, 32'h0);
    end
    ws_force_en  = 1'b1;
    ws_force_val = 1'b1;
    drain();

    // Reset in the middle of a wait, then a stray response.
    issue(mk(1, 3'b000, 1, 1, 5'd12, 32'h0000_4000, 32'h200), 32'h1111_2222, 10, 0, 32'h0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    exp_q.delete();
    sram_q.delete();
    resp_arrived = 1'b0;
    #1;
    check("midrst_allowin", {69'd0, ms_if.ms_allowin},     70'd1);
    check("midrst_valid",   {69'd0, ms_if.ms_to_ws_valid}, 70'd0);
    check("midrst_fwd_bus", {31'd0, ms_if.ms_fwd_bus},     70'd0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    begin
      sram_t s;
      s.dly   = 1;
      s.rdata = 32'h5555_AAAA;
      sram_q.push_back(s);
    end
    repeat (6) @(posedge clk);
    @(negedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage in-order pipeline, directly downstream of the execute stage and upstream of write-back. It accepts one instruction per handshake from execute and waits for the data-SRAM response when the instruction issued a memory request. It extracts and extends load data by size and byte offset, and buffers a response that arrives while write-back is stalled. It also drives a forwarding/interlock bus back to decode.

## Interface
Parameters: none.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- ws_allowin  in  1  write-back can accept this cycle
- ms_allowin  out  1  this stage can accept this cycle
- es_to_ms_valid  in  1  execute presents a valid instruction
- es_to_ms_bus  in  75  {mem_req, ld_op[2:0], res_from_mem, gr_we, dest[4:0], alu_result[31:0], pc[31:0]}, MSB first
- data_sram_data_ok  in  1  response strobe for the oldest outstanding request
- data_sram_rdata  in  32  response data, valid while data_ok=1
- ms_to_ws_valid  out  1  valid instruction offered to write-back
- ms_to_ws_bus  out  70  {gr_we, dest[4:0], final_result[31:0], pc[31:0]}
- ms_fwd_bus  out  39  {fwd_we, fwd_dest[4:0], fwd_data[31:0], fwd_pending}

## Operation
- Registers: ms_valid, bus_r[74:0], buf_valid, buf_data[31:0].
- Accept rule: on ms_allowin=1, ms_valid ← es_to_ms_valid.
  - If es_to_ms_valid=1, bus_r ← es_to_ms_bus and buf_valid ← 0.
- mem_req=1 marks any load or store issued by execute. Each one receives exactly one data_ok.
- resp_done = buf_valid | data_sram_data_ok.
- ms_ready_go = !mem_req_r | resp_done.
- ms_allowin = !ms_valid | (ms_ready_go & ws_allowin).
- ms_to_ws_valid = ms_valid & ms_ready_go.
- Buffering: if ms_valid & mem_req_r & !buf_valid & data_ok & !ws_allowin, then buf_valid ← 1 and buf_data ← rdata.
  - The held value is presented until the handshake completes.
  - raw_data = buf_valid ? buf_data : data_sram_rdata.
- A data_ok seen while !ms_valid, !mem_req_r, or buf_valid=1 is a protocol violation. It is ignored and state is unchanged.
- Load extraction uses offset = alu_result[1:0]:
  - ld_op 000 (ld.w): raw_data.
  - ld_op 001 (ld.b): byte raw_data[8*offset+7 : 8*offset], sign-extended.
  - ld_op 011 (ld.bu): same byte, zero-extended.
  - ld_op 010 (ld.h): half selected by offset[1] (bit 0 ignored; alignment is checked elsewhere), sign-extended.
  - ld_op 100 (ld.hu): same half, zero-extended.
  - ld_op 101–111: treated as ld.w.
- final_result = res_from_mem ? extracted load data : alu_result.
- gr_we and dest are passed through unchanged. A store has mem_req=1, res_from_mem=0 and gr_we=0.
- ms_fwd_bus fields:
  - fwd_we = ms_valid & gr_we.
  - fwd_dest = dest.
  - fwd_data = final_result.
  - fwd_pending = ms_valid & res_from_mem & !resp_done. Decode must stall rather than forward while fwd_pending=1.

## Timing
- Reset (asynchronous, immediate): ms_valid=0, buf_valid=0, bus_r=0, buf_data=0.
  - Resulting outputs: ms_allowin=1, ms_to_ws_valid=0, ms_to_ws_bus=0, ms_fwd_bus=0.
- Latency: one cycle. An instruction accepted at edge N is offered to write-back in cycle N+1 if ready.
- Zero-stall case: data_ok is asserted in the first cycle the instruction is in this stage. Throughput is then 1 instruction per cycle.
- Wait case: data_ok arrives k cycles late. The stage holds, ms_to_ws_valid=0 and ms_allowin=0 for k cycles, and bus_r stays stable.
- ms_to_ws_bus is stable while ms_to_ws_valid=1 and ws_allowin=0. The buffer guarantees this after data_ok drops.
- Simultaneous events:
  - Handshake-out and accept-in in the same cycle: the new instruction replaces the old one and buf_valid clears.
  - data_ok and ws_allowin=1 in the same cycle: data is consumed directly and nothing is buffered.
- Reset mid-wait drops the instruction and clears the buffer. The SRAM side is reset by the same signal.
- All outputs are combinational from registers plus data_ok, rdata and ws_allowin. There are no combinational paths from es_to_ms_*.

## Test plan
- Zero-stall ld.w: alu_result=0x1000, data_ok in the cycle after accept, rdata=0x12345678 → ms_to_ws_valid=1 that cycle, final_result=0x12345678, fwd_pending=0.
- ld.b offset 3 with rdata=0x80FF1234 → final_result=0xFFFFFF80. ld.bu at offset 2 → 0x000000FF. ld.hu at offset 2 → 0x000080FF. ld.h at offset 0 → 0x00001234.
- Delayed response: data_ok arrives 3 cycles late → ms_allowin=0, ms_to_ws_valid=0 and fwd_pending=1 for 3 cycles, then the result appears.
- Buffered response: data_ok with rdata=0xCAFEF00D while ws_allowin=0 → buf_valid=1. Hold ws_allowin=0 for 2 more cycles with rdata changing → final_result stays 0xCAFEF00D until the handshake.
- Non-memory instruction (mem_req=0, alu_result=0xA5A5A5A5, gr_we=1, dest=7) → no wait. ms_fwd_bus gives fwd_we=1, fwd_dest=7, fwd_data=0xA5A5A5A5.
- Reset asserted mid-wait → ms_valid=0 and ms_allowin=1 immediately. A stray data_ok afterwards produces no output.
